nib_pack: RTL

- Downstream consumer of the nibble-max selector (nm2).
- Takes the winning nibble and its 2-bit source id each valid cycle and pairs consecutive winners into one byte plus a 4-bit id tag.
- Buffers the packed words in a small FIFO and drains them through a valid/ready port toward the serializer/bus side.

---
 rtl/nib_pack_pkg.sv | 39 +++
 rtl/nib_pack_if.sv | 36 +++
 rtl/nib_fifo.sv | 57 +++++
 rtl/nib_pack.sv | 100 ++++++++++
 4 files changed

// File: rtl/nib_pack_pkg.sv
// nib_pack shared types: id codes, pairing states, packed word layout.
// Imported by the FIFO, the top and the bench.
package nib_pack_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int WORD_W    = 12;

  localparam logic [1:0] ID_A = 2'd0;
  localparam logic [1:0] ID_B = 2'd1;
  localparam logic [1:0] ID_C = 2'd2;
  localparam logic [1:0] ID_D = 2'd3;

  typedef enum logic {
    EMPTY_HALF = 1'b0,
    HAVE_HALF  = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] nib_hi;
    logic [3:0] nib_lo;
    logic [1:0] id_hi;
    logic [1:0] id_lo;
  } word_t;

  function automatic word_t pack_word(
    input logic [3:0] nib_hi,
    input logic [3:0] nib_lo,
    input logic [1:0] id_hi,
    input logic [1:0] id_lo
  );
    word_t w;
    w.nib_hi = nib_hi;
    w.nib_lo = nib_lo;
    w.id_hi  = id_hi;
    w.id_lo  = id_lo;
    return w;
  endfunction

endpackage

// File: rtl/nib_pack_if.sv
// Nibble input and packed-word output handshake bundle.
// slave = nib_pack side, master = producer/consumer side.
interface nib_pack_if;

  logic       in_valid;
  logic [3:0] nibble_mayor;
  logic [1:0] id_mayor;
  logic       flush;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] byte_out;
  logic [3:0] tag_out;

  modport master (
    output in_valid,
    output nibble_mayor,
    output id_mayor,
    output flush,
    output out_ready,
    input  out_valid,
    input  byte_out,
    input  tag_out
  );

  modport slave (
    input  in_valid,
    input  nibble_mayor,
    input  id_mayor,
    input  flush,
    input  out_ready,
    output out_valid,
    output byte_out,
    output tag_out
  );

endinterface

// File: rtl/nib_fifo.sv
// Fall-through FIFO for packed words; head reads 0 when empty.
// A push into a full FIFO is accepted only alongside a pop.
module nib_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1,
  parameter int W     = 12
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          push_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nib_pack.sv
// Pairs consecutive winning nibbles into byte + id tag words
// and queues them toward the serializer side.
module nib_pack
  import nib_pack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_L,
  nib_pack_if.slave     bus,
  output logic          half_pend,
  output logic [CW-1:0] fifo_count,
  output logic          full,
  output logic          overflow
);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] hold_nib;
  logic [1:0] hold_id;
  logic       load;
  logic       clear;
  logic       pair_done;
  logic       push_ok;
  logic       empty;
  word_t      wword;
  word_t      head;

  // Flush beats pair completion; a same-cycle nibble starts a new pair.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clear     = 1'b0;
    pair_done = 1'b0;
    unique case (1'b1)
      bus.flush: begin
        load      = bus.in_valid;
        clear     = !bus.in_valid;
        state_nxt = bus.in_valid ? HAVE_HALF : EMPTY_HALF;
      end
      !bus.flush && bus.in_valid && (state == EMPTY_HALF): begin
        load      = 1'b1;
        state_nxt = HAVE_HALF;
      end
      !bus.flush && bus.in_valid && (state == HAVE_HALF): begin
        pair_done = 1'b1;
        state_nxt = EMPTY_HALF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= EMPTY_HALF;
      hold_nib <= '0;
      hold_id  <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        hold_nib <= bus.nibble_mayor;
        hold_id  <= bus.id_mayor;
      end else if (clear) begin
        hold_nib <= '0;
        hold_id  <= '0;
      end
      if (pair_done && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  assign wword = pack_word(hold_nib, bus.nibble_mayor,
                           hold_id, bus.id_mayor);

  nib_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .W     (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (pair_done),
    .pop     (bus.out_ready),
    .wdata   (wword),
    .rdata   (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty),
    .push_ok (push_ok)
  );

  assign half_pend     = (state == HAVE_HALF);
  assign bus.out_valid = !empty;
  assign bus.byte_out  = {head.nib_hi, head.nib_lo};
  assign bus.tag_out   = {head.id_hi, head.id_lo};

endmodule
